// File: rtl/ram_init_ctrl.sv
// ram_init_ctrl: fills a memory region over AXI4 write with fixed-length INCR bursts, one burst outstanding.
module ram_init_ctrl #(
  parameter int          ID_WIDTH  = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] MEM_SIZE  = 32'h100000,
  parameter int          BURST_LEN = 16,
  parameter logic [63:0] PATTERN   = 64'h0,
  parameter bit          ADDR_DATA = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_init_done,
  output logic                o_init_error,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_e;
  localparam logic [31:0] STEP     = 32'(BURST_LEN * 8);
  localparam logic [31:0] LAST     = BASE_ADDR + MEM_SIZE - STEP;
  localparam logic [7:0]  BEAT_MAX = 8'(BURST_LEN - 1);
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, beat_addr;
  logic [7:0]  beat_q, beat_d;
  logic        err_q, err_d, last_beat, start_ok, b_hs;
  logic        unused_bid;
  assign unused_bid = ^i_bid;
  assign last_beat  = beat_q == BEAT_MAX;
  assign start_ok   = i_start && (state_q == IDLE || state_q == DONE);
  assign b_hs       = state_q == RESP && i_bvalid;
  assign beat_addr  = addr_q + {21'd0, beat_q, 3'd0};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      beat_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = i_start ? ADDR : state_q;
      ADDR:       state_d = i_awready ? DATA : ADDR;
      DATA:       state_d = (i_wready && last_beat) ? RESP : DATA;
      RESP:       state_d = i_bvalid ? ((addr_q == LAST) ? DONE : ADDR) : RESP;
      default:    state_d = IDLE;
    endcase
    addr_d = start_ok ? BASE_ADDR : b_hs ? addr_q + STEP : addr_q;
    beat_d = (state_q == DATA && i_wready) ? (last_beat ? 8'd0 : beat_q + 8'd1) : beat_q;
    err_d  = start_ok ? 1'b0 : err_q | (b_hs && i_bresp != 2'b00);
  end
  always_comb begin
    o_awvalid    = state_q == ADDR;
    o_wvalid     = state_q == DATA;
    o_bready     = state_q == RESP;
    o_busy       = state_q == ADDR || state_q == DATA || state_q == RESP;
    o_init_done  = state_q == DONE;
    o_init_error = err_q;
    o_wlast      = state_q == DATA && last_beat;
    o_awaddr     = addr_q;
    o_wdata      = ADDR_DATA ? {beat_addr + 32'd4, beat_addr} : PATTERN;
  end
  assign o_awid    = '0;
  assign o_awlen   = BEAT_MAX;
  assign o_awsize  = 3'd3;
  assign o_awburst = 2'b01;
  assign o_wstrb   = 8'hFF;
endmodule

// File: doc/ram_init_ctrl.md
RAM_INIT_CTRL -- requirements
Module: ram_init_ctrl

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 6, meaning the width of AXI write ID.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0, meaning the first byte address written.
REQ-003 The block SHALL have parameter MEM_SIZE, default 32'h100000, meaning the bytes to initialise; it is a multiple of BURST_LEN*8.
REQ-004 The block SHALL have parameter BURST_LEN, default 16, meaning beats per burst, range 1..256.
REQ-005 The block SHALL have parameter PATTERN, default 64'h0, meaning the fill data when ADDR_DATA=0.
REQ-006 The block SHALL have parameter ADDR_DATA, default 0; when 1, each beat's data SHALL be {beat_addr+4, beat_addr}.
REQ-007 The block SHALL have the following ports, listed as name direction width meaning:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  start-fill pulse
- o_busy  out  1  fill in progress
- o_init_done  out  1  fill complete, sticky
- o_init_error  out  1  non-OKAY response seen, sticky
- o_awid  out  ID_WIDTH  constant 0
- o_awaddr  out  32  burst start address
- o_awlen  out  8  BURST_LEN-1
- o_awsize  out  3  constant 3 (8 bytes)
- o_awburst  out  2  constant 2'b01 (INCR)
- o_awvalid  out  1  and i_awready in 1
- o_wdata  out  64  and o_wstrb out 8, constant 8'hFF
- o_wlast  out  1  final beat of burst
- o_wvalid  out  1  and i_wready in 1
- i_bid  in  ID_WIDTH  ignored
- i_bresp  in  2  write response
- i_bvalid  in  1  and o_bready out 1

Function
REQ-008 The FSM SHALL have the states IDLE, ADDR, DATA, RESP and DONE; only one burst is outstanding at a time.
REQ-009 In IDLE, i_start=1 SHALL load the address to BASE_ADDR, clear done/error, and go to ADDR on the next cycle.
REQ-010 In ADDR, o_awvalid=1 and o_awaddr SHALL be held stable until i_awready=1; after the handshake the FSM SHALL go to DATA.
REQ-011 In DATA, o_wvalid=1; the beat counter SHALL advance only on i_wready=1; o_wlast=1 exactly on beat BURST_LEN-1; after the wlast handshake the FSM SHALL go to RESP.
REQ-012 o_wdata SHALL hold stable while o_wvalid=1 and i_wready=0; with ADDR_DATA=1, beat_addr = burst address + 8*beat index.
REQ-013 In RESP, o_bready SHALL be 1; on i_bvalid=1, i_bresp!=2'b00 SHALL set o_init_error; the address SHALL advance by BURST_LEN*8.
REQ-014 After the B handshake: if the address just written was BASE_ADDR+MEM_SIZE-BURST_LEN*8, the FSM SHALL go to DONE; otherwise to ADDR.
REQ-015 An error SHALL NOT abort the fill; all bursts complete.
REQ-016 In DONE: o_init_done=1, o_busy=0; i_start=1 SHALL restart as from IDLE.
REQ-017 o_busy SHALL be 1 in ADDR, DATA and RESP only.
REQ-018 i_start SHALL be ignored while o_busy=1.
REQ-019 o_awvalid, o_wvalid and o_bready SHALL never be asserted together, and never outside their own state.
REQ-020 Address arithmetic SHALL be 32-bit; no wrap occurs for legal parameters.

Reset
REQ-021 rst=1 SHALL, at the next clock edge, force IDLE and set o_busy, o_init_done, o_init_error, o_awvalid, o_wvalid, o_wlast and o_bready to 0, regardless of state.
REQ-022 rst mid-burst SHALL abandon the burst with no further valid asserted; the downstream slave is reset by the same rst.

Verification
REQ-023 Basic fill: MEM_SIZE=256, BURST_LEN=4, slave always ready, OKAY -> 8 bursts at 0x00,0x20..0xE0, awlen=3, wlast on every 4th beat; o_init_done=1 after the 8th B; memory all PATTERN.
REQ-024 ADDR_DATA=1, same setup -> the word at byte 0x28 reads 64'h0000002C_00000028.
REQ-025 Backpressure: random i_awready/i_wready/i_bvalid stalls of 0..5 cycles -> awaddr/wdata stable while stalled, same memory image as REQ-023, no dropped or extra beats.
REQ-026 Error: slave returns i_bresp=2'b10 on burst 3 only -> o_init_error=1 sticky, all 8 bursts still issued, o_init_done=1.
REQ-027 Reset and restart: rst asserted during burst 5 DATA -> next cycle all outputs 0; i_start while busy is ignored; i_start in DONE clears done/error and repeats the 8 bursts.
